ball_motion_sched: RTL and testbench



---
 rtl/ball_motion_sched_if.sv | 34 +++
 rtl/ball_motion_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_ball_motion_sched.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ball_motion_sched_if.sv
// Port bundle for ball_motion_sched: frame-sync inputs and the packed
// position buses plus status flags that the field lookups read.
// slave: the motion scheduler; master: whatever drives v_sync/enable.
interface ball_motion_sched_if #(
  parameter int unsigned NUM_BALLS = 2
);
  logic                      v_sync;
  logic                      enable;
  logic [10*NUM_BALLS-1:0]   ball_x;
  logic [10*NUM_BALLS-1:0]   ball_y;
  logic                      busy;
  logic                      frame_done;
  logic                      overrun;

  modport master (
    output v_sync,
    output enable,
    input  ball_x,
    input  ball_y,
    input  busy,
    input  frame_done,
    input  overrun
  );

  modport slave (
    input  v_sync,
    input  enable,
    output ball_x,
    output ball_y,
    output busy,
    output frame_done,
    output overrun
  );
endinterface

// File: rtl/ball_motion_sched.sv
// Per-frame motion controller for the metaball renderer. Holds position and
// velocity of NUM_BALLS balls and walks one shared update datapath over them
// (FETCH -> CALC -> WRITE per ball, then DONE) once per v_sync falling edge.
// Optional build macro BALL_BOUNCE_EN: a rejected move on an axis negates that
// axis velocity instead of applying the +/-1 centring adjustment.
module ball_motion_sched #(
  parameter int unsigned NUM_BALLS     = 2,
  parameter int unsigned SCREEN_WIDTH  = 800,
  parameter int unsigned SCREEN_HEIGHT = 600,
  parameter int unsigned BALL_SIZE     = 128
) (
  input  logic                 clk_50mhz,
  input  logic                 reset_n,
  ball_motion_sched_if.slave   bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StCalc  = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam int unsigned SpanX = SCREEN_WIDTH - BALL_SIZE;
  localparam int unsigned SpanY = SCREEN_HEIGHT - BALL_SIZE;

  localparam logic [9:0] LimX    = 10'(SpanX);
  localparam logic [9:0] LimY    = 10'(SpanY);
  localparam logic [9:0] MidX    = 10'(SCREEN_WIDTH / 2);
  localparam logic [9:0] MidY    = 10'(SCREEN_HEIGHT / 2);
  localparam logic [2:0] LastIdx = 3'(NUM_BALLS - 1);

  // Evenly spaced start positions across the usable span.
  function automatic logic [9:0] init_pos(input int unsigned span, input int i);
    return 10'(span * (i + 1) / (NUM_BALLS + 1));
  endfunction

  // v_sync synchronizer and edge-detect history.
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync_prev_q, sync_prev_d;
  logic frame_start;

  // Sequencer.
  logic [2:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       overrun_q, overrun_d;

  // Per-ball state.
  logic [9:0] pos_x_q [NUM_BALLS];
  logic [9:0] pos_x_d [NUM_BALLS];
  logic [9:0] pos_y_q [NUM_BALLS];
  logic [9:0] pos_y_d [NUM_BALLS];
  logic [9:0] vel_x_q [NUM_BALLS];
  logic [9:0] vel_x_d [NUM_BALLS];
  logic [9:0] vel_y_q [NUM_BALLS];
  logic [9:0] vel_y_d [NUM_BALLS];

  // Work registers loaded in FETCH, results captured in CALC.
  logic [9:0] cur_x_q, cur_x_d;
  logic [9:0] cur_y_q, cur_y_d;
  logic [9:0] cur_vx_q, cur_vx_d;
  logic [9:0] cur_vy_q, cur_vy_d;
  logic [9:0] new_x_q, new_x_d;
  logic [9:0] new_y_q, new_y_d;
  logic [9:0] new_vx_q, new_vx_d;
  logic [9:0] new_vy_q, new_vy_d;

  // Shared datapath signals.
  logic [9:0] step_x, step_y;
  logic [9:0] nx, ny;
  logic       ok_x, ok_y;
  logic [9:0] adj_x, adj_y;
  logic [9:0] calc_x, calc_y, calc_vx, calc_vy;

  assign frame_start = sync_prev_q & ~sync2_q;

  // Shared update datapath: one ball's next position/velocity from work regs.
  always_comb begin
    step_x = {{2{cur_vx_q[9]}}, cur_vx_q[9:2]};
    step_y = {{2{cur_vy_q[9]}}, cur_vy_q[9:2]};
    nx     = cur_x_q + step_x;
    ny     = cur_y_q + step_y;
    // Unsigned compare: a step below zero wraps high and is rejected here.
    ok_x   = (nx != 10'd0) && (nx < LimX);
    ok_y   = (ny != 10'd0) && (ny < LimY);
    calc_x = ok_x ? nx : cur_x_q;
    calc_y = ok_y ? ny : cur_y_q;
    adj_x  = (cur_x_q < MidX) ? 10'd1 : 10'h3ff;
    adj_y  = (cur_y_q < MidY) ? 10'd1 : 10'h3ff;
`ifdef BALL_BOUNCE_EN
    calc_vx = ok_x ? (cur_vx_q + adj_x) : (~cur_vx_q + 10'd1);
    calc_vy = ok_y ? (cur_vy_q + adj_y) : (~cur_vy_q + 10'd1);
`else
    calc_vx = cur_vx_q + adj_x;
    calc_vy = cur_vy_q + adj_y;
`endif
  end

  // Next-state: synchronizer, sequencer, work registers and ball storage.
  always_comb begin
    sync1_d     = bus.v_sync;
    sync2_d     = sync1_q;
    sync_prev_d = sync2_q;
    state_d     = state_q;
    idx_d       = idx_q;
    overrun_d   = overrun_q | (frame_start & (state_q != StIdle));
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    vel_x_d     = vel_x_q;
    vel_y_d     = vel_y_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    cur_vx_d    = cur_vx_q;
    cur_vy_d    = cur_vy_q;
    new_x_d     = new_x_q;
    new_y_d     = new_y_q;
    new_vx_d    = new_vx_q;
    new_vy_d    = new_vy_q;

    case (state_q)
      StIdle: begin
        if (frame_start && bus.enable) begin
          state_d = StFetch;
          idx_d   = 3'd0;
        end
      end
      StFetch: begin
        for (int i = 0; i < NUM_BALLS; i++) begin
          if (idx_q == 3'(i)) begin
            cur_x_d  = pos_x_q[i];
            cur_y_d  = pos_y_q[i];
            cur_vx_d = vel_x_q[i];
            cur_vy_d = vel_y_q[i];
          end
        end
        state_d = StCalc;
      end
      StCalc: begin
        new_x_d  = calc_x;
        new_y_d  = calc_y;
        new_vx_d = calc_vx;
        new_vy_d = calc_vy;
        state_d  = StWrite;
      end
      StWrite: begin
        for (int i = 0; i < NUM_BALLS; i++) begin
          if (idx_q == 3'(i)) begin
            pos_x_d[i] = new_x_q;
            pos_y_d[i] = new_y_q;
            vel_x_d[i] = new_vx_q;
            vel_y_d[i] = new_vy_q;
          end
        end
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = StFetch;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset restores start positions immediately.
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      sync_prev_q <= 1'b1;
      state_q     <= StIdle;
      idx_q       <= 3'd0;
      overrun_q   <= 1'b0;
      cur_x_q     <= 10'd0;
      cur_y_q     <= 10'd0;
      cur_vx_q    <= 10'd0;
      cur_vy_q    <= 10'd0;
      new_x_q     <= 10'd0;
      new_y_q     <= 10'd0;
      new_vx_q    <= 10'd0;
      new_vy_q    <= 10'd0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        pos_x_q[i] <= init_pos(SpanX, i);
        pos_y_q[i] <= init_pos(SpanY, i);
        vel_x_q[i] <= 10'd0;
        vel_y_q[i] <= 10'd0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync_prev_q <= sync_prev_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      overrun_q   <= overrun_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      cur_vx_q    <= cur_vx_d;
      cur_vy_q    <= cur_vy_d;
      new_x_q     <= new_x_d;
      new_y_q     <= new_y_d;
      new_vx_q    <= new_vx_d;
      new_vy_q    <= new_vy_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      vel_x_q     <= vel_x_d;
      vel_y_q     <= vel_y_d;
    end
  end

  // Outputs: packed position buses and status decoded from the sequencer.
  always_comb begin
    bus.ball_x = '0;
    bus.ball_y = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      bus.ball_x[10*i +: 10] = pos_x_q[i];
      bus.ball_y[10*i +: 10] = pos_y_q[i];
    end
    bus.busy       = (state_q != StIdle);
    bus.frame_done = (state_q == StDone);
    bus.overrun    = overrun_q;
  end

endmodule

// File: tb/tb_ball_motion_sched.sv
// Bench for ball_motion_sched: a default two-ball instance plus a one-ball
// instance on a 4-pixel-wide track so the boundary rejection is reached by
// ordinary frames. Directed table, hand sequences and randomized frames are
// all checked against a per-ball arithmetic model.
module tb_ball_motion_sched;

  localparam int NA  = 2;
  localparam int NB  = 1;
  localparam int WB  = 132;
  localparam int HB  = 600;
  localparam int BS  = 128;
  localparam int SEQ = 3 * NA + 1;

`ifdef BALL_BOUNCE_EN
  localparam int BX7 = 1;
  localparam int BX9 = 2;
`else
  localparam int BX7 = 3;
  localparam int BX9 = 3;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic vs    = 1'b1;
  logic en    = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ball_motion_sched_if #(.NUM_BALLS(NA)) bus_a ();
  ball_motion_sched_if #(.NUM_BALLS(NB)) bus_b ();

  assign bus_a.v_sync = vs;
  assign bus_a.enable = en;
  assign bus_b.v_sync = vs;
  assign bus_b.enable = en;

  ball_motion_sched #(.NUM_BALLS(NA)) dut_a (
    .clk_50mhz (clk),
    .reset_n   (rst_n),
    .bus       (bus_a)
  );

  ball_motion_sched #(
    .NUM_BALLS     (NB),
    .SCREEN_WIDTH  (WB),
    .SCREEN_HEIGHT (HB),
    .BALL_SIZE     (BS)
  ) dut_b (
    .clk_50mhz (clk),
    .reset_n   (rst_n),
    .bus       (bus_b)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int x;
    int y;
    int vx;
    int vy;
  } ball_t;

  ball_t ma [NA];
  ball_t mb [NB];

  function automatic int wrap10(input int v);
    return ((v % 1024) + 1024) % 1024;
  endfunction

  function automatic int swrap10(input int v);
    int u;
    u = wrap10(v);
    return (u >= 512) ? u - 1024 : u;
  endfunction

  function automatic int floor4(input int v);
    return (v >= 0) ? v / 4 : -((-v + 3) / 4);
  endfunction

  function automatic void move_axis(input int p, input int v, input int lim, input int mid,
                                    output int np, output int nv);
    int  cand;
    bit  ok;
    cand = wrap10(p + floor4(v));
    ok   = (cand > 0) && (cand < lim);
    np   = ok ? cand : p;
`ifdef BALL_BOUNCE_EN
    nv   = ok ? swrap10(v + ((p < mid) ? 1 : -1)) : swrap10(-v);
`else
    nv   = swrap10(v + ((p < mid) ? 1 : -1));
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      ma[i].x  = (800 - BS) * (i + 1) / (NA + 1);
      ma[i].y  = (600 - BS) * (i + 1) / (NA + 1);
      ma[i].vx = 0;
      ma[i].vy = 0;
    end
    for (int i = 0; i < NB; i++) begin
      mb[i].x  = (WB - BS) * (i + 1) / (NB + 1);
      mb[i].y  = (HB - BS) * (i + 1) / (NB + 1);
      mb[i].vx = 0;
      mb[i].vy = 0;
    end
  endtask

  task automatic model_frame();
    int np, nv;
    for (int i = 0; i < NA; i++) begin
      move_axis(ma[i].x, ma[i].vx, 800 - BS, 400, np, nv);
      ma[i].x = np; ma[i].vx = nv;
      move_axis(ma[i].y, ma[i].vy, 600 - BS, 300, np, nv);
      ma[i].y = np; ma[i].vy = nv;
    end
    for (int i = 0; i < NB; i++) begin
      move_axis(mb[i].x, mb[i].vx, WB - BS, WB / 2, np, nv);
      mb[i].x = np; mb[i].vx = nv;
      move_axis(mb[i].y, mb[i].vy, HB - BS, HB / 2, np, nv);
      mb[i].y = np; mb[i].vy = nv;
    end
  endtask

  function automatic logic [63:0] pack_a(input bit want_y);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NA; i++) r[10*i +: 10] = 10'(want_y ? ma[i].y : ma[i].x);
    return r;
  endfunction

  function automatic logic [63:0] pack_b(input bit want_y);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[10*i +: 10] = 10'(want_y ? mb[i].y : mb[i].x);
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " a.x"}, 64'(bus_a.ball_x), pack_a(1'b0));
    chk({tag, " a.y"}, 64'(bus_a.ball_y), pack_a(1'b1));
    chk({tag, " b.x"}, 64'(bus_b.ball_x), pack_b(1'b0));
    chk({tag, " b.y"}, 64'(bus_b.ball_y), pack_b(1'b1));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " a.x"}, 64'(bus_a.ball_x), 64'({10'd448, 10'd224}));
    chk({tag, " a.y"}, 64'(bus_a.ball_y), 64'({10'd314, 10'd157}));
    chk({tag, " b.x"}, 64'(bus_b.ball_x), 64'd2);
    chk({tag, " b.y"}, 64'(bus_b.ball_y), 64'd236);
    chk({tag, " busy"}, 64'(bus_a.busy), 64'd0);
    chk({tag, " frame_done"}, 64'(bus_a.frame_done), 64'd0);
    chk({tag, " overrun"}, 64'(bus_a.overrun), 64'd0);
  endtask

  // One v_sync low pulse of lowlen cycles at k=0; optional second fall at k=second.
  // Observes 20 cycles, counting busy cycles and the cycle of frame_done.
  task automatic run_frame(input bit fen, input int lowlen, input int second,
                           output int busy_cnt, output int fd_k);
    en       = fen;
    busy_cnt = 0;
    fd_k     = -1;
    @(posedge clk); #1;
    vs = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus_a.busy) busy_cnt++;
      if (bus_a.frame_done && fd_k < 0) fd_k = k;
      if (k == lowlen) vs = 1'b1;
      if (second > 0 && k == second) vs = 1'b0;
      if (second > 0 && k == second + 1) vs = 1'b1;
    end
    if (fen) model_frame();
    chk_model("model");
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit en;
    int second;
    int exp_busy;
    int exp_fd_k;
    int exp_x0;
    int exp_x1;
    bit exp_ov;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int bc, fk;

    vecs[0] = '{1'b1, 0, 7, 9, 224, 448, 1'b0};
    vecs[1] = '{1'b1, 0, 7, 9, 224, 447, 1'b0};
    vecs[2] = '{1'b1, 0, 7, 9, 224, 446, 1'b0};
    vecs[3] = '{1'b1, 0, 7, 9, 224, 445, 1'b0};
    vecs[4] = '{1'b1, 0, 7, 9, 225, 444, 1'b0};
    vecs[5] = '{1'b0, 0, 0, -1, 225, 444, 1'b0};
    vecs[6] = '{1'b0, 0, 0, -1, 225, 444, 1'b0};
    vecs[7] = '{1'b0, 0, 0, -1, 225, 444, 1'b0};
    vecs[8] = '{1'b1, 3, 7, 9, 226, 442, 1'b1};

    model_reset();

    // Reset held, then released.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset held");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("after reset");

    // Directed frames from reset.
    for (int r = 0; r < 9; r++) begin
      run_frame(vecs[r].en, 1, vecs[r].second, bc, fk);
      chk($sformatf("row%0d busy cycles", r), 64'(bc), 64'(vecs[r].exp_busy));
      chk($sformatf("row%0d frame_done cycle", r), 64'(fk), 64'(vecs[r].exp_fd_k));
      chk($sformatf("row%0d x0", r), 64'(bus_a.ball_x[9:0]), 64'(vecs[r].exp_x0));
      chk($sformatf("row%0d x1", r), 64'(bus_a.ball_x[19:10]), 64'(vecs[r].exp_x1));
      chk($sformatf("row%0d overrun", r), 64'(bus_a.overrun), 64'(vecs[r].exp_ov));
    end

    // Narrow-track ball reaches its limits: 7th and 9th accepted frames.
    run_frame(1'b1, 1, 0, bc, fk);
    chk("boundary b.x frame7", 64'(bus_b.ball_x), 64'(BX7));
    run_frame(1'b1, 1, 0, bc, fk);
    run_frame(1'b1, 1, 0, bc, fk);
    chk("boundary b.x frame9", 64'(bus_b.ball_x), 64'(BX9));

    // Asynchronous reset in the middle of ball 1's CALC.
    en = 1'b1;
    @(posedge clk); #1;
    vs = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k == 1) vs = 1'b1;
    end
    chk("mid-seq busy before reset", 64'(bus_a.busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async reset");
    model_reset();
    #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("after async reset");

    // Randomized frames against the model.
    for (int f = 0; f < 40; f++) begin
      bit fen;
      fen = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run_frame(fen, int'($urandom_range(1, 4)), 0, bc, fk);
      chk($sformatf("rand%0d busy cycles", f), 64'(bc), 64'(fen ? SEQ : 0));
      chk($sformatf("rand%0d frame_done cycle", f), 64'(fk), 64'(fen ? SEQ + 2 : -1));
      chk($sformatf("rand%0d overrun", f), 64'(bus_a.overrun | bus_b.overrun), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
